// File: rtl/display_scan_controller.sv
// Read-side sequencer for display_memory: scans the front buffer row by row, streams pixels with
// latch/blank strobes, and defers buffer swaps to the frame boundary so no frame is torn.
module display_scan_controller #(
  parameter int unsigned ROWS         = 8,
  parameter int unsigned COLUMNS      = 32,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable_i,
  input  logic                       flip_req_i,
  output logic                       flip_ack_o,
  output logic                       flip_o,
  output logic [$clog2(ROWS)-1:0]    rrow_o,
  output logic [$clog2(COLUMNS)-1:0] rcol_o,
  input  logic [23:0]                rdata_i,
  output logic [23:0]                pix_data_o,
  output logic                       pix_valid_o,
  output logic [$clog2(ROWS)-1:0]    row_addr_o,
  output logic                       latch_o,
  output logic                       blank_o,
  output logic                       frame_start_o
);

  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned ColW = $clog2(COLUMNS);
  localparam int unsigned BlkW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StDrain,
    StLatch,
    StBlank
  } state_e;

  state_e            state_q;
  logic [RowW-1:0]   row_q;
  logic [RowW-1:0]   rrow_q;
  logic [ColW-1:0]   col_q;
  logic [BlkW-1:0]   blk_q;
  logic [RowW-1:0]   row_addr_q;
  logic              flip_q;
  logic              pending_q;
  logic              flip_ack_q;
  logic              latch_q;
  logic              blank_q;
  logic              pix_valid_q;
  logic              frame_start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      row_q         <= '0;
      rrow_q        <= '0;
      col_q         <= '0;
      blk_q         <= '0;
      row_addr_q    <= '0;
      flip_q        <= 1'b0;
      pending_q     <= 1'b0;
      flip_ack_q    <= 1'b0;
      latch_q       <= 1'b0;
      blank_q       <= 1'b1;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      latch_q       <= 1'b0;
      frame_start_q <= 1'b0;
      flip_ack_q    <= 1'b0;
      pix_valid_q   <= 1'b0;
      if (flip_req_i) begin
        pending_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          blank_q <= 1'b1;
          row_q   <= '0;
          rrow_q  <= '0;
          col_q   <= '0;
          if (enable_i) begin
            state_q       <= StRead;
            blank_q       <= 1'b0;
            frame_start_q <= 1'b1;
          end
        end

        StRead: begin
          // Column counter wraps back to 0 on the last column, leaving rcol at 0 outside READ.
          col_q       <= col_q + 1'b1;
          pix_valid_q <= 1'b1;
          if (col_q == ColW'(COLUMNS - 1)) begin
            state_q <= StDrain;
          end
        end

        StDrain: begin
          state_q    <= StLatch;
          latch_q    <= 1'b1;
          blank_q    <= 1'b1;
          row_addr_q <= row_q;
        end

        StLatch: begin
          state_q <= StBlank;
          blk_q   <= '0;
        end

        StBlank: begin
          if (blk_q == BlkW'(BLANK_CYCLES - 1)) begin
            row_q <= row_q + 1'b1;
            // Frame boundary: the only place the buffer swap may commit.
            if (row_q == RowW'(ROWS - 1)) begin
              pending_q <= 1'b0;
              if (pending_q || flip_req_i) begin
                flip_q     <= ~flip_q;
                flip_ack_q <= 1'b1;
              end
            end
            if (enable_i) begin
              state_q       <= StRead;
              blank_q       <= 1'b0;
              rrow_q        <= row_q + 1'b1;
              frame_start_q <= (row_q == RowW'(ROWS - 1));
            end else begin
              state_q <= StIdle;
              rrow_q  <= '0;
            end
          end else begin
            blk_q <= blk_q + 1'b1;
          end
        end

        default: begin
          state_q <= StIdle;
          blank_q <= 1'b1;
        end
      endcase
    end
  end

  assign flip_ack_o    = flip_ack_q;
  assign flip_o        = flip_q;
  assign rrow_o        = rrow_q;
  assign rcol_o        = col_q;
  assign pix_valid_o   = pix_valid_q;
  assign pix_data_o    = pix_valid_q ? rdata_i : '0;
  assign row_addr_o    = row_addr_q;
  assign latch_o       = latch_q;
  assign blank_o       = blank_q;
  assign frame_start_o = frame_start_q;

endmodule
